// File: rtl/gshare_predictor.sv
// Gshare branch predictor: a PHT of saturating counters indexed by PC xor speculative
// global history, predicting combinationally for fetch and trained from ROB commits.
module gshare_predictor #(
    parameter int INDEX_BITS = 8,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 8,
    parameter int CTR_INIT   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                IF_valid,
    input  logic [31:0]         IF_inst,
    input  logic [31:0]         IF_pc,
    output logic                IF_need_jump,
    output logic [31:0]         IF_predicted_imm,
    output logic [GHR_BITS-1:0] IF_ghr,
    input  logic                ROB_input_valid,
    input  logic [31:0]         ROB_pc,
    input  logic                ROB_taken,
    input  logic                ROB_mispredict,
    input  logic [GHR_BITS-1:0] ROB_ghr
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX   = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'(CTR_INIT);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [CTR_BITS-1:0]   pht_q [DEPTH];
    logic [CTR_BITS-1:0]   pht_d [DEPTH];
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;

    logic [INDEX_BITS-1:0] fidx, ridx;
    logic                  is_jal, is_branch;
    logic [31:0]           j_imm, b_imm;
    logic [GHR_BITS-1:0]   ghr_spec, ghr_rec;
    logic [CTR_BITS-1:0]   ctr_old, ctr_new;
    logic                  unused_pc_bits;

    assign fidx = IF_pc[INDEX_BITS+1:2]  ^ INDEX_BITS'(ghr_q);
    assign ridx = ROB_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ROB_ghr);

    assign is_jal    = (IF_inst[6:0] == OP_JAL);
    assign is_branch = (IF_inst[6:0] == OP_BRANCH);
    assign j_imm = {{12{IF_inst[31]}}, IF_inst[19:12], IF_inst[20], IF_inst[30:21], 1'b0};
    assign b_imm = {{20{IF_inst[31]}}, IF_inst[7], IF_inst[30:25], IF_inst[11:8], 1'b0};

    always_comb begin
        IF_need_jump     = 1'b0;
        IF_predicted_imm = j_imm;
        if (is_jal) begin
            IF_need_jump = 1'b1;
        end else if (is_branch) begin
            IF_need_jump     = pht_q[fidx][CTR_BITS-1];
            IF_predicted_imm = b_imm;
        end
    end

    assign IF_ghr = ghr_q;

    // A one-bit history has nothing to shift; the new outcome simply replaces it.
    generate
        if (GHR_BITS == 1) begin : g_ghr1
            assign ghr_spec = IF_need_jump;
            assign ghr_rec  = ROB_taken;
        end else begin : g_ghrn
            assign ghr_spec = {ghr_q[GHR_BITS-2:0], IF_need_jump};
            assign ghr_rec  = {ROB_ghr[GHR_BITS-2:0], ROB_taken};
        end
    endgenerate

    assign ctr_old = pht_q[ridx];

    always_comb begin
        ctr_new = ctr_old;
        if (ROB_taken && ctr_old != CTR_MAX)
            ctr_new = ctr_old + 1'b1;
        else if (!ROB_taken && ctr_old != '0)
            ctr_new = ctr_old - 1'b1;
    end

    // Recovery is checked last so it overrides a wrong-path speculative shift.
    always_comb begin
        pht_d = pht_q;
        ghr_d = ghr_q;
        if (rdy) begin
            if (IF_valid && is_branch)
                ghr_d = ghr_spec;
            if (ROB_input_valid && ROB_mispredict)
                ghr_d = ghr_rec;
            if (ROB_input_valid)
                pht_d[ridx] = ctr_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                pht_q[i] <= CTR_RESET;
            ghr_q <= '0;
        end else begin
            pht_q <= pht_d;
            ghr_q <= ghr_d;
        end
    end

    assign unused_pc_bits = ^{IF_pc[31:INDEX_BITS+2], IF_pc[1:0],
                              ROB_pc[31:INDEX_BITS+2], ROB_pc[1:0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: reset, decode, counter saturation, GHR shift,
// misprediction recovery, rdy freeze and mid-run reset.
module tb_gshare_predictor;

    localparam logic [31:0] INST_B   = 32'hFE000CE3;  // beq x0,x0,-8
    localparam logic [31:0] INST_JAL = 32'h0080006F;  // jal x0,+8
    localparam logic [31:0] INST_ALU = 32'h00000013;  // addi x0,x0,0

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        IF_valid;
    logic [31:0] IF_inst, IF_pc;
    logic        IF_need_jump;
    logic [31:0] IF_predicted_imm;
    logic [7:0]  IF_ghr;
    logic        ROB_input_valid;
    logic [31:0] ROB_pc;
    logic        ROB_taken, ROB_mispredict;
    logic [7:0]  ROB_ghr;

    int n_assert = 0;
    int n_fail   = 0;

    gshare_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .IF_valid         (IF_valid),
        .IF_inst          (IF_inst),
        .IF_pc            (IF_pc),
        .IF_need_jump     (IF_need_jump),
        .IF_predicted_imm (IF_predicted_imm),
        .IF_ghr           (IF_ghr),
        .ROB_input_valid  (ROB_input_valid),
        .ROB_pc           (ROB_pc),
        .ROB_taken        (ROB_taken),
        .ROB_mispredict   (ROB_mispredict),
        .ROB_ghr          (ROB_ghr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a B-type at pc without consuming it and check the prediction bit.
    task automatic peek(input string tag, input logic [31:0] pc, input logic exp);
        IF_valid = 1'b0;
        IF_inst  = INST_B;
        IF_pc    = pc;
        #1;
        chk(tag, {31'b0, IF_need_jump}, {31'b0, exp});
    endtask

    task automatic rob(input logic [31:0] pc, input logic [7:0] ghr,
                       input logic taken, input logic misp);
        ROB_input_valid = 1'b1;
        ROB_pc          = pc;
        ROB_ghr         = ghr;
        ROB_taken       = taken;
        ROB_mispredict  = misp;
        step();
        ROB_input_valid = 1'b0;
        ROB_mispredict  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] inst, input logic [31:0] pc);
        IF_valid = 1'b1;
        IF_inst  = inst;
        IF_pc    = pc;
        step();
        IF_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        IF_valid = 1'b0; IF_inst = INST_ALU; IF_pc = '0;
        ROB_input_valid = 1'b0; ROB_pc = '0; ROB_taken = 1'b0;
        ROB_mispredict = 1'b0; ROB_ghr = '0;
        step(); step();
        rst = 1'b0;

        // 1: reset state and decode
        IF_inst = INST_B; IF_pc = 32'h100; #1;
        chk("rst_need_jump", {31'b0, IF_need_jump}, 32'd0);
        chk("rst_ghr", {24'b0, IF_ghr}, 32'h0);
        chk("b_imm", IF_predicted_imm, 32'hFFFFFFF8);
        IF_inst = INST_JAL; #1;
        chk("jal_need_jump", {31'b0, IF_need_jump}, 32'd1);
        chk("jal_imm", IF_predicted_imm, 32'h8);
        IF_inst = INST_ALU; #1;
        chk("alu_need_jump", {31'b0, IF_need_jump}, 32'd0);

        // 2: saturation; the update cycle still reads the old counter
        IF_inst = INST_B; IF_pc = 32'h100;
        ROB_input_valid = 1'b1; ROB_pc = 32'h100; ROB_ghr = 8'h00; ROB_taken = 1'b1;
        #1;
        chk("same_cycle_old", {31'b0, IF_need_jump}, 32'd0);
        step();
        ROB_input_valid = 1'b0;
        peek("ctr2", 32'h100, 1'b1);
        rob(32'h100, 8'h00, 1'b1, 1'b0); peek("ctr3", 32'h100, 1'b1);
        rob(32'h100, 8'h00, 1'b1, 1'b0); peek("ctr3_sat", 32'h100, 1'b1);
        rob(32'h100, 8'h00, 1'b0, 1'b0); peek("ctr_dn2", 32'h100, 1'b1);
        rob(32'h100, 8'h00, 1'b0, 1'b0); peek("ctr_dn1", 32'h100, 1'b0);
        rob(32'h100, 8'h00, 1'b0, 1'b0); peek("ctr_dn0", 32'h100, 1'b0);
        rob(32'h100, 8'h00, 1'b0, 1'b0); peek("ctr0_sat", 32'h100, 1'b0);
        rob(32'h100, 8'h00, 1'b1, 1'b0); peek("ctr_up1", 32'h100, 1'b0);

        // 3: speculative shift with predictions 1,0,1 (entries 0x40=2, 0x41=1, 0x42=3)
        rob(32'h100, 8'h00, 1'b1, 1'b0);
        rob(32'h108, 8'h00, 1'b1, 1'b0);
        rob(32'h108, 8'h00, 1'b1, 1'b0);
        peek("pred_a", 32'h100, 1'b1);
        fetch(INST_B, 32'h100);
        chk("ghr_01", {24'b0, IF_ghr}, 32'h01);
        peek("pred_b", 32'h100, 1'b0);
        fetch(INST_B, 32'h100);
        chk("ghr_02", {24'b0, IF_ghr}, 32'h02);
        peek("pred_c", 32'h100, 1'b1);
        fetch(INST_B, 32'h100);
        chk("ghr_05", {24'b0, IF_ghr}, 32'h05);
        fetch(INST_JAL, 32'h200);
        fetch(INST_ALU, 32'h204);
        chk("ghr_jal_alu", {24'b0, IF_ghr}, 32'h05);

        // 4: recovery beats a same-cycle taken-predicted fetch (idx 0x47^0x05=0x42)
        peek("pred_wrongpath", 32'h11C, 1'b1);
        IF_valid = 1'b1;
        ROB_input_valid = 1'b1; ROB_pc = 32'h200; ROB_ghr = 8'h05;
        ROB_taken = 1'b0; ROB_mispredict = 1'b1;
        step();
        IF_valid = 1'b0; ROB_input_valid = 1'b0; ROB_mispredict = 1'b0;
        chk("ghr_recover", {24'b0, IF_ghr}, 32'h0A);

        // 5: rdy=0 freezes; entry 0x40 (=2) is read at pc 0x128 with GHR 0x0A
        rdy = 1'b0;
        IF_valid = 1'b1; IF_inst = INST_B; IF_pc = 32'h100;
        rob(32'h100, 8'h00, 1'b0, 1'b1);
        IF_valid = 1'b0;
        chk("frz_ghr", {24'b0, IF_ghr}, 32'h0A);
        peek("frz_pht", 32'h128, 1'b1);
        rdy = 1'b1;
        rob(32'h100, 8'h00, 1'b0, 1'b0);
        peek("resume_pht", 32'h128, 1'b0);
        chk("resume_ghr_hold", {24'b0, IF_ghr}, 32'h0A);
        fetch(INST_B, 32'h128);
        chk("resume_ghr", {24'b0, IF_ghr}, 32'h14);

        // 6: GHR=0x03 via recovery, train entry 0x40 from pc 0x10C, then reset
        rob(32'h300, 8'h01, 1'b1, 1'b1);
        chk("ghr_03", {24'b0, IF_ghr}, 32'h03);
        rob(32'h10C, 8'h03, 1'b1, 1'b0);
        rob(32'h10C, 8'h03, 1'b1, 1'b0);
        peek("pred_40", 32'h10C, 1'b1);
        chk("ghr_03_hold", {24'b0, IF_ghr}, 32'h03);
        rst = 1'b1; rdy = 1'b0;
        rob(32'h10C, 8'h03, 1'b1, 1'b1);
        rst = 1'b0; rdy = 1'b1;
        chk("rst2_ghr", {24'b0, IF_ghr}, 32'h0);
        peek("rst2_pht40", 32'h100, 1'b0);
        peek("rst2_pht42", 32'h108, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
